// File: rtl/ui_pkg.sv
// rtl/ui_pkg.sv - character constants and state type shared by the UART user interface
package ui_pkg;

   localparam logic [7:0] CHAR_BS        = 8'h08;
   localparam logic [7:0] CHAR_DEL       = 8'h7F;
   localparam logic [7:0] CHAR_CR        = 8'h0D;
   localparam logic [7:0] CHAR_LF        = 8'h0A;
   localparam logic [7:0] CHAR_SP        = 8'h20;
   localparam logic [7:0] CHAR_BEL       = 8'h07;
   localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
   localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;

   typedef enum logic [2:0] {
      COLLECT,
      ECHO_SP,
      ECHO_BS2,
      ECHO_LF,
      LINE_RDY
   } line_rx_state_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= CHAR_PRINT_MIN) && (c <= CHAR_PRINT_MAX);
   endfunction

endpackage

// File: rtl/ui_line_ram.sv
// rtl/ui_line_ram.sv - line buffer, one write port and one registered read port
module ui_line_ram #(
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH + 1),
   localparam int IW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Addresses past the array hold the previous read value rather than index out of range.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= 8'h00;
      end else if (rd_addr < AW'(DEPTH)) begin
         rd_data <= mem[rd_addr[IW-1:0]];
      end
   end

endmodule

// File: rtl/ui_line_rx.sv
// rtl/ui_line_rx.sv - assembles received bytes into an edited command line and echoes them
module ui_line_rx
   import ui_pkg::*;
#(
   parameter int MAX_LINE = 64,
   localparam int LEN_W = $clog2(MAX_LINE + 1),
   localparam int IW = $clog2(MAX_LINE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_data,
   input  logic             rx_data_rdy,
   input  logic             rx_frm_err,
   input  logic             echo_fifo_full,
   output logic             echo_fifo_wr_en,
   output logic [7:0]       echo_fifo_din,
   output logic             line_val,
   output logic [LEN_W-1:0] line_len,
   input  logic [LEN_W-1:0] line_rd_addr,
   output logic [7:0]       line_rd_data,
   input  logic             line_ack,
   output logic             rx_drop
);

   line_rx_state_t   state_q, state_d;
   logic [LEN_W-1:0] len_d;
   logic             echo_want;
   logic [7:0]       echo_byte;
   logic             ram_we;
   logic             drop_d;
   logic             val_d;
   logic             rx_ok;
   logic             is_erase;

   assign rx_ok    = rx_data_rdy && !rx_frm_err;
   assign is_erase = (rx_data == CHAR_BS) || (rx_data == CHAR_DEL);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: begin
            if (rx_ok && is_erase && (line_len != '0)) begin
               state_d = ECHO_SP;
            end else if (rx_ok && (rx_data == CHAR_CR)) begin
               state_d = ECHO_LF;
            end
         end
         ECHO_SP:  state_d = ECHO_BS2;
         ECHO_BS2: state_d = COLLECT;
         ECHO_LF:  state_d = LINE_RDY;
         LINE_RDY: if (line_ack) state_d = COLLECT;
         default:  state_d = COLLECT;
      endcase
   end

   always_comb begin
      echo_want = 1'b0;
      echo_byte = 8'h00;
      len_d     = line_len;
      ram_we    = 1'b0;
      drop_d    = 1'b0;
      val_d     = 1'b0;
      case (state_q)
         COLLECT: begin
            if (rx_data_rdy && rx_frm_err) begin
               drop_d = 1'b1;
            end else if (rx_data_rdy && is_printable(rx_data)) begin
               echo_want = 1'b1;
               if (line_len < LEN_W'(MAX_LINE)) begin
                  ram_we    = 1'b1;
                  len_d     = line_len + LEN_W'(1);
                  echo_byte = rx_data;
               end else begin
                  echo_byte = CHAR_BEL;
               end
            end else if (rx_data_rdy && is_erase && (line_len != '0)) begin
               len_d     = line_len - LEN_W'(1);
               echo_want = 1'b1;
               echo_byte = CHAR_BS;
            end else if (rx_data_rdy && (rx_data == CHAR_CR)) begin
               echo_want = 1'b1;
               echo_byte = CHAR_CR;
            end
         end
         ECHO_SP: begin
            echo_want = 1'b1;
            echo_byte = CHAR_SP;
            drop_d    = rx_data_rdy;
         end
         ECHO_BS2: begin
            echo_want = 1'b1;
            echo_byte = CHAR_BS;
            drop_d    = rx_data_rdy;
         end
         ECHO_LF: begin
            echo_want = 1'b1;
            echo_byte = CHAR_LF;
            drop_d    = rx_data_rdy;
         end
         LINE_RDY: begin
            drop_d = rx_data_rdy;
            if (line_ack) begin
               len_d = '0;
            end else begin
               val_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // A full FIFO only suppresses the strobe; the edit and state walk proceed unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         echo_fifo_wr_en <= 1'b0;
         echo_fifo_din   <= 8'h00;
         line_val        <= 1'b0;
         line_len        <= '0;
         rx_drop         <= 1'b0;
      end else begin
         echo_fifo_wr_en <= echo_want && !echo_fifo_full;
         if (echo_want) begin
            echo_fifo_din <= echo_byte;
         end
         line_val <= val_d;
         line_len <= len_d;
         rx_drop  <= drop_d;
      end
   end

   ui_line_ram #(.DEPTH(MAX_LINE)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (ram_we),
      .wr_addr (line_len[IW-1:0]),
      .wr_data (rx_data),
      .rd_addr (line_rd_addr),
      .rd_data (line_rd_data)
   );

endmodule

// File: tb/tb_ui_line_rx.sv
// tb/tb_ui_line_rx.sv - scoreboard bench for ui_line_rx with a four-character line buffer
module tb_ui_line_rx;

   localparam int MAX_LINE = 4;
   localparam int LEN_W = $clog2(MAX_LINE + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_data_rdy = 1'b0;
   logic             rx_frm_err = 1'b0;
   logic             echo_fifo_full = 1'b0;
   logic             echo_fifo_wr_en;
   logic [7:0]       echo_fifo_din;
   logic             line_val;
   logic [LEN_W-1:0] line_len;
   logic [LEN_W-1:0] line_rd_addr = '0;
   logic [7:0]       line_rd_data;
   logic             line_ack = 1'b0;
   logic             rx_drop;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_echo [$];
   int         exp_drop [$];

   always #5 clk = ~clk;

   ui_line_rx #(.MAX_LINE(MAX_LINE)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rx_data         (rx_data),
      .rx_data_rdy     (rx_data_rdy),
      .rx_frm_err      (rx_frm_err),
      .echo_fifo_full  (echo_fifo_full),
      .echo_fifo_wr_en (echo_fifo_wr_en),
      .echo_fifo_din   (echo_fifo_din),
      .line_val        (line_val),
      .line_len        (line_len),
      .line_rd_addr    (line_rd_addr),
      .line_rd_data    (line_rd_data),
      .line_ack        (line_ack),
      .rx_drop         (rx_drop)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every echo strobe and drop pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (echo_fifo_wr_en === 1'b1) begin
         if (exp_echo.size() == 0) begin
            chk("echo_unexpected", {24'h0, echo_fifo_din}, 32'hFFFF_FFFF);
         end else begin
            chk("echo_byte", {24'h0, echo_fifo_din}, {24'h0, exp_echo.pop_front()});
         end
      end
      if (rx_drop === 1'b1) begin
         if (exp_drop.size() == 0) begin
            chk("drop_unexpected", 32'd1, 32'd0);
         end else begin
            void'(exp_drop.pop_front());
            checks++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // exp_wr: 0 or 1 checks the strobe one cycle after the byte, 2 skips that check.
   task automatic send(input logic [7:0] b, input logic frm, input int exp_wr);
      rx_data     = b;
      rx_frm_err  = frm;
      rx_data_rdy = 1'b1;
      tick();
      rx_data_rdy = 1'b0;
      rx_frm_err  = 1'b0;
      if (exp_wr != 2) chk("echo_latency", {31'h0, echo_fifo_wr_en}, exp_wr);
      repeat (4) tick();
   endtask

   task automatic push_echo(input logic [7:0] b);
      exp_echo.push_back(b);
   endtask

   task automatic read_chk(input int addr, input logic [7:0] exp);
      line_rd_addr = LEN_W'(addr);
      tick();
      chk("rd_data", {24'h0, line_rd_data}, {24'h0, exp});
   endtask

   task automatic wait_line();
      int n = 0;
      while (line_val !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("line_val_wait", {31'h0, line_val}, 32'd1);
   endtask

   task automatic ack_line();
      line_ack = 1'b1;
      tick();
      line_ack = 1'b0;
      chk("ack_line_val", {31'h0, line_val}, 32'd0);
      chk("ack_line_len", {29'h0, line_len}, 32'd0);
   endtask

   task automatic sb_empty();
      chk("echo_q_empty", exp_echo.size(), 32'd0);
      chk("drop_q_empty", exp_drop.size(), 32'd0);
   endtask

   initial begin
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_wr_en", {31'h0, echo_fifo_wr_en}, 32'd0);
      chk("rst_din", {24'h0, echo_fifo_din}, 32'd0);
      chk("rst_line_val", {31'h0, line_val}, 32'd0);
      chk("rst_line_len", {29'h0, line_len}, 32'd0);
      chk("rst_rd_data", {24'h0, line_rd_data}, 32'd0);
      chk("rst_rx_drop", {31'h0, rx_drop}, 32'd0);

      // "ab" CR
      push_echo(8'h61); send(8'h61, 1'b0, 1);
      push_echo(8'h62); send(8'h62, 1'b0, 1);
      push_echo(8'h0D); push_echo(8'h0A); send(8'h0D, 1'b0, 1);
      wait_line();
      chk("ab_len", {29'h0, line_len}, 32'd2);
      read_chk(0, 8'h61);
      read_chk(1, 8'h62);
      sb_empty();
      ack_line();

      // "abc" BS "d" CR
      push_echo(8'h61); send(8'h61, 1'b0, 1);
      push_echo(8'h62); send(8'h62, 1'b0, 1);
      push_echo(8'h63); send(8'h63, 1'b0, 1);
      push_echo(8'h08); push_echo(8'h20); push_echo(8'h08); send(8'h08, 1'b0, 1);
      chk("bs_len", {29'h0, line_len}, 32'd2);
      push_echo(8'h64); send(8'h64, 1'b0, 1);
      push_echo(8'h0D); push_echo(8'h0A); send(8'h0D, 1'b0, 1);
      wait_line();
      chk("abd_len", {29'h0, line_len}, 32'd3);
      read_chk(0, 8'h61);
      read_chk(1, 8'h62);
      read_chk(2, 8'h64);
      sb_empty();
      ack_line();

      // BS on empty line, then empty line
      send(8'h08, 1'b0, 0);
      push_echo(8'h0D); push_echo(8'h0A); send(8'h0D, 1'b0, 1);
      wait_line();
      chk("empty_len", {29'h0, line_len}, 32'd0);
      sb_empty();
      ack_line();

      // overflow: fifth printable echoes BEL
      push_echo(8'h61); send(8'h61, 1'b0, 1);
      push_echo(8'h62); send(8'h62, 1'b0, 1);
      push_echo(8'h63); send(8'h63, 1'b0, 1);
      push_echo(8'h64); send(8'h64, 1'b0, 1);
      push_echo(8'h07); send(8'h65, 1'b0, 1);
      chk("full_len", {29'h0, line_len}, 32'd4);
      read_chk(0, 8'h61);
      read_chk(3, 8'h64);
      push_echo(8'h0D); push_echo(8'h0A); send(8'h0D, 1'b0, 1);
      wait_line();

      // byte while a line is pending is dropped
      exp_drop.push_back(1); send(8'h78, 1'b0, 0);
      chk("rdy_len_hold", {29'h0, line_len}, 32'd4);
      chk("rdy_val_hold", {31'h0, line_val}, 32'd1);
      sb_empty();
      ack_line();
      push_echo(8'h79); send(8'h79, 1'b0, 1);
      read_chk(0, 8'h79);
      chk("y_len", {29'h0, line_len}, 32'd1);
      push_echo(8'h08); push_echo(8'h20); push_echo(8'h08); send(8'h7F, 1'b0, 1);
      chk("del_len", {29'h0, line_len}, 32'd0);

      // echo suppressed while the FIFO is full, edits still apply
      echo_fifo_full = 1'b1;
      send(8'h61, 1'b0, 0);
      chk("nofifo_len1", {29'h0, line_len}, 32'd1);
      send(8'h08, 1'b0, 0);
      chk("nofifo_len0", {29'h0, line_len}, 32'd0);
      echo_fifo_full = 1'b0;

      // framing error and ignored control byte
      exp_drop.push_back(1); send(8'h7A, 1'b1, 0);
      chk("frm_len", {29'h0, line_len}, 32'd0);
      send(8'h0A, 1'b0, 0);
      chk("lf_len", {29'h0, line_len}, 32'd0);
      sb_empty();

      // reset in the middle of a backspace echo cuts it short
      push_echo(8'h71); send(8'h71, 1'b0, 1);
      push_echo(8'h08);
      rx_data = 8'h08;
      rx_data_rdy = 1'b1;
      tick();
      rx_data_rdy = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      chk("rst_mid_len", {29'h0, line_len}, 32'd0);
      sb_empty();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ui_line_rx.md
# ui_line_rx

Receive-side adapter for the UART user interface. It accepts bytes from the UART receiver and assembles them into a command line with backspace editing. It echoes every accepted character into the TX character FIFO, which the character sequencer drains. When a CR arrives it presents the completed line to the command parser through a synchronous read port and a valid/ack handshake.

## Interface
- MAX_LINE, 64: line buffer capacity in characters; must be ≥ 2.
- LEN_W, $clog2(MAX_LINE+1): width of the length field (localparam, derived).
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- rx_data  in  8  byte from the UART receiver.
- rx_data_rdy  in  1  one-cycle pulse; rx_data is valid this cycle.
- rx_frm_err  in  1  qualifies rx_data_rdy; the byte has a framing error.
- echo_fifo_full  in  1  TX character FIFO is full.
- echo_fifo_wr_en  out  1  write strobe to the TX character FIFO.
- echo_fifo_din  out  8  echo byte.
- line_val  out  1  a completed line is available.
- line_len  out  LEN_W  number of characters in the line, 0..MAX_LINE.
- line_rd_addr  in  LEN_W  read address into the line buffer.
- line_rd_data  out  8  character at line_rd_addr, registered.
- line_ack  in  1  one-cycle pulse from the parser; the line is consumed.
- rx_drop  out  1  one-cycle pulse when a received byte is discarded.

## Operation
- Reset values: echo_fifo_wr_en=0, echo_fifo_din=0, line_val=0, line_len=0, line_rd_data=0, rx_drop=0, state=COLLECT. Buffer contents are not cleared.
- States:
  - COLLECT: accepts bytes.
  - ECHO_SP: echoes space during a backspace.
  - ECHO_BS2: echoes the final backspace.
  - ECHO_LF: echoes LF after CR.
  - LINE_RDY: holds the completed line.
- COLLECT, rx_data_rdy with rx_frm_err=1: discard the byte, pulse rx_drop, no echo.
- COLLECT, printable byte (0x20–0x7E):
  - If line_len < MAX_LINE: write the byte to buffer[line_len], increment line_len, echo the byte.
  - If line_len = MAX_LINE: do not store; echo BEL (0x07).
- COLLECT, BS (0x08) or DEL (0x7F):
  - If line_len > 0: decrement line_len, echo BS, go to ECHO_SP.
  - If line_len = 0: no action, no echo.
- ECHO_SP → echo 0x20 → ECHO_BS2. ECHO_BS2 → echo 0x08 → COLLECT.
- COLLECT, CR (0x0D): echo CR, go to ECHO_LF. ECHO_LF → echo 0x0A → LINE_RDY.
- An empty line (line_len=0) is a valid line.
- COLLECT, LF (0x0A) or any other control byte: ignored, no echo, no rx_drop.
- LINE_RDY: line_val=1 and line_len is held stable.
  - Every rx_data_rdy is discarded with an rx_drop pulse.
  - On line_ack: line_val←0, line_len←0, state←COLLECT.
  - line_ack outside LINE_RDY is ignored.
- rx_data_rdy in ECHO_SP, ECHO_BS2 or ECHO_LF: byte discarded, rx_drop pulses. This cannot happen at legal baud rates.
- Echo with echo_fifo_full=1: the echo byte is skipped (no wr_en), the state sequence advances normally, and the edit itself still takes effect.
- line_rd_data is valid in any state. Reading an address ≥ line_len returns stale contents.

## Timing
- Echo of a single byte: echo_fifo_wr_en is high for 1 cycle, in the cycle after rx_data_rdy.
- Backspace echo: 3 consecutive wr_en cycles carrying 08, 20, 08, starting the cycle after rx_data_rdy.
- CR echo: 2 consecutive wr_en cycles carrying 0D, 0A. line_val rises in the cycle after the LF write.
- line_len updates 1 cycle after rx_data_rdy.
- line_rd_data has 1-cycle read latency from line_rd_addr.
- line_ack → line_val low on the next cycle. A byte can be accepted in the cycle after that.
- rx_drop asserts 1 cycle after the discarded rx_data_rdy.
- Reset asserted mid-sequence aborts the sequence immediately. No partial echo continues after reset is released.

## Structure
- Shared package ui_pkg holds:
  - character constants CHAR_BS, CHAR_DEL, CHAR_CR, CHAR_LF, CHAR_SP, CHAR_BEL, and the printable range bounds;
  - the line_rx_state_t enum.
- Sub-module ui_line_ram: MAX_LINE×8 simple dual-port RAM with one write port and one synchronous read port.
- The FSM, line_len counter and echo mux live in ui_line_rx.

## Test plan
- Send "ab", CR → echo writes 61, 62, 0D, 0A; line_val=1, line_len=2; reading addr 0/1 returns 61/62.
- Send "abc", BS, "d", CR → echo 61 62 63 08 20 08 64 0D 0A; line_len=3; buffer reads 61 62 64.
- BS with line_len=0, then CR → no echo for the BS; echo 0D 0A; line_val=1, line_len=0.
- MAX_LINE=4: send "abcde" → fifth byte echoes 07; line_len=4; buffer reads 61–64.
- In LINE_RDY, send "x" → rx_drop pulse, line_len unchanged; line_ack → line_val=0, line_len=0; a following "y" is stored at addr 0.
- Hold echo_fifo_full=1 and send "a", BS → no wr_en; line_len returns to 0. Byte with rx_frm_err=1 → rx_drop, line_len unchanged.
